// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencing for an mm:ss stopwatch plus 4-digit display scan.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 100_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [5:0] disp_sec,
    output logic [5:0] disp_min,
    output logic       running,
    output logic       lap_active,
    output logic       ovf,
    output logic [1:0] digit_sel,
    output logic [3:0] an
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
    state_t        state;
    logic [TW-1:0] presc;
    logic [SW-1:0] scan_presc;
    logic [5:0]    sec_cnt, min_cnt, lap_sec, lap_min;
    logic          tick, sec_wrap, min_wrap;
    assign tick       = presc == TW'(TICK_DIV - 1);
    assign sec_wrap   = sec_cnt == 6'd59;
    assign min_wrap   = min_cnt == 6'd59;
    assign running    = state == RUN || state == LAP;
    assign lap_active = state == LAP;
    assign disp_sec   = lap_active ? lap_sec : sec_cnt;
    assign disp_min   = lap_active ? lap_min : min_cnt;
    assign an         = ~(4'b0001 << digit_sel);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            scan_presc <= '0;
            digit_sel  <= 2'd0;
            sec_cnt    <= 6'd0;
            min_cnt    <= 6'd0;
            lap_sec    <= 6'd0;
            lap_min    <= 6'd0;
            ovf        <= 1'b0;
        end else begin
            ovf        <= 1'b0;
            scan_presc <= scan_presc == SW'(SCAN_DIV - 1) ? '0 : scan_presc + SW'(1);
            digit_sel  <= scan_presc == SW'(SCAN_DIV - 1) ? digit_sel + 2'd1 : digit_sel;
            // clear beats start beats lap; a tick coinciding with clear or start is dropped
            if (btn_clear) begin
                state   <= IDLE;
                presc   <= '0;
                sec_cnt <= 6'd0;
                min_cnt <= 6'd0;
                lap_sec <= 6'd0;
                lap_min <= 6'd0;
            end else if (btn_start) begin
                if (state == IDLE || state == PAUSE) begin
                    state <= RUN;
                    presc <= '0;
                end else begin
                    state <= PAUSE;
                end
            end else begin
                if (btn_lap && state == RUN) begin
                    state   <= LAP;
                    lap_sec <= sec_cnt;
                    lap_min <= min_cnt;
                end else if (btn_lap && state == LAP) begin
                    state <= RUN;
                end
                if (running) begin
                    presc <= tick ? '0 : presc + TW'(1);
                    if (tick) begin
                        sec_cnt <= sec_wrap ? 6'd0 : sec_cnt + 6'd1;
                        min_cnt <= !sec_wrap ? min_cnt : min_wrap ? 6'd0 : min_cnt + 6'd1;
                        ovf     <= sec_wrap && min_wrap;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench; an elapsed-seconds model predicts every cycle's outputs.
module tb_stopwatch_ctrl;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
    localparam logic [20:0] RST_VEC = {6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1110};
    logic clk = 1'b0, rst_n = 1'b0, btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
    logic [5:0] disp_sec, disp_min;
    logic running, lap_active, ovf;
    logic [1:0] digit_sel;
    logic [3:0] an;
    int errors = 0, checks = 0;
    int mode, total, lap_total, ph, sc;
    logic [3:0] an_tab [4];
    logic [20:0] exp_q [$];
    logic [20:0] mon_act, mon_exp;
    always #5 clk = ~clk;
    stopwatch_ctrl #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .disp_sec(disp_sec), .disp_min(disp_min), .running(running), .lap_active(lap_active),
        .ovf(ovf), .digit_sel(digit_sel), .an(an)
    );
    function automatic logic [20:0] out_vec();
        return {disp_min, disp_sec, running, lap_active, ovf, digit_sel, an};
    endfunction
    task automatic model_reset();
        mode = M_IDLE;
        total = 0;
        lap_total = 0;
        ph = 0;
        sc = 0;
    endtask
    // Time is kept as whole elapsed seconds (mod one hour) plus cycles since the last second.
    task automatic model_edge(input logic c, input logic s, input logic l);
        logic ov;
        bit counting;
        int shown;
        ov = 1'b0;
        if (c) begin
            mode = M_IDLE;
            total = 0;
            ph = 0;
            lap_total = 0;
        end else if (s) begin
            if (mode == M_IDLE || mode == M_PAUSE) begin
                mode = M_RUN;
                ph = 0;
            end else begin
                mode = M_PAUSE;
            end
        end else begin
            counting = mode == M_RUN || mode == M_LAP;
            if (l && mode == M_RUN) begin
                lap_total = total;
                mode = M_LAP;
            end else if (l && mode == M_LAP) begin
                mode = M_RUN;
            end
            if (counting) begin
                ph++;
                if (ph == TD) begin
                    ph = 0;
                    total = (total + 1) % 3600;
                    ov = total == 0;
                end
            end
        end
        sc++;
        shown = mode == M_LAP ? lap_total : total;
        exp_q.push_back({6'(shown / 60), 6'(shown % 60), 1'(mode == M_RUN || mode == M_LAP),
                         1'(mode == M_LAP), ov, 2'((sc / SD) % 4), an_tab[(sc / SD) % 4]});
    endtask
    task automatic step(input logic c, input logic s, input logic l);
        @(negedge clk);
        btn_clear = c;
        btn_start = s;
        btn_lap = l;
        model_edge(c, s, l);
    endtask
    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask
    task automatic release_rst();
        @(negedge clk);
        btn_clear = 1'b0;
        btn_start = 1'b0;
        btn_lap = 1'b0;
        rst_n = 1'b1;
        model_edge(1'b0, 1'b0, 1'b0);
    endtask
    task automatic check_reset(input string tag);
        checks++;
        if (out_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, out_vec(), RST_VEC);
        end
    endtask
    initial forever begin
        @(posedge clk);
        #2;
        if (rst_n) begin
            mon_act = out_vec();
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow t=%0t: output %h with no expected entry", $time, mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL cycle t=%0t: got min=%0d sec=%0d run=%b lap=%b ovf=%b dsel=%0d an=%b, want min=%0d sec=%0d run=%b lap=%b ovf=%b dsel=%0d an=%b",
                             $time, mon_act[20:15], mon_act[14:9], mon_act[8], mon_act[7], mon_act[6], mon_act[5:4], mon_act[3:0],
                             mon_exp[20:15], mon_exp[14:9], mon_exp[8], mon_exp[7], mon_exp[6], mon_exp[5:4], mon_exp[3:0]);
                end
            end
        end
    end
    initial begin
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset("reset_hold");
        release_rst();
        idle(9);
        step(1'b0, 1'b1, 1'b0); idle(20);
        step(1'b0, 1'b1, 1'b0); idle(20);
        step(1'b0, 1'b1, 1'b0); idle(6);
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0); idle(12);
        step(1'b0, 1'b0, 1'b1); idle(16);
        step(1'b0, 1'b0, 1'b1); idle(6);
        step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0); idle(3600 * TD + 8);
        step(1'b1, 1'b1, 1'b1); idle(3);
        step(1'b0, 1'b1, 1'b0); idle(5);
        step(1'b0, 1'b1, 1'b0); idle(3);
        step(1'b0, 1'b1, 1'b1); idle(9);
        step(1'b0, 1'b0, 1'b1); idle(7);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_reset("reset_held");
        release_rst();
        repeat (4000)
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 7) == 0));
        idle(1);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
